uart_dec_formatter: RTL
=======================

# uart_dec_formatter

Converts a 16-bit unsigned measurement, such as a detected pitch in Hz, into its ASCII decimal text with leading zeros suppressed. Each result is terminated by a line ending. The block sits directly upstream of the UART transmitter, delivering one byte per valid/ready transfer into its `data_i`/`valid_i`/`ready_o` interface.

## Interface
- `crlf_p`, default 1: 1 terminates each message with CR then LF (8'h0D, 8'h0A); 0 terminates with LF only.
- `clk_i`  in  1  single clock; all logic in this domain.
- `reset_i`  in  1  reset, asynchronous and active-high.
- `value_i`  in  16  unsigned binary value to format.
- `valid_i`  in  1  `value_i` is valid.
- `ready_o`  out  1  block can accept a value; a value is accepted in a cycle where `valid_i && ready_o`.
- `data_o`  out  8  ASCII byte to the transmitter.
- `valid_o`  out  1  `data_o` is valid.
- `ready_i`  in  1  transmitter accepts the byte; a byte is transferred in a cycle where `valid_o && ready_i`.

## Operation
- **Reset values:** `ready_o`=0, `valid_o`=0, `data_o`=8'h00, state IDLE.
  - While `reset_i` is high, the outputs hold these values.
  - Assertion mid-message takes effect immediately (asynchronous) and discards the message.
  - `ready_o` rises on the first clock edge after `reset_i` deasserts.
- **States:** IDLE, CONVERT, LOAD, SEND_DIGIT, SEND_CR, SEND_LF.
- **IDLE:** `ready_o`=1, `valid_o`=0. On acceptance:
  - latch `value_i` into the shift register;
  - clear the 20-bit BCD register;
  - load the 5-bit iteration count with 16;
  - drop `ready_o`;
  - go to CONVERT.
- **CONVERT:** sequential double-dabble, one bit per cycle. In each cycle:
  - every BCD nibble ≥5 gets +3;
  - then {bcd, shift} shifts left by 1;
  - the count decrements.
  - After 16 iterations, go to LOAD.
- **LOAD:**
  - Digit index ← position of the most significant nonzero BCD digit (4..0); if all digits are zero, index ← 0, so at least one digit is sent.
  - Go to SEND_DIGIT.
- **SEND_DIGIT:**
  - `valid_o`=1, `data_o`=8'h30 + digit[index].
  - On transfer: if index=0, go to SEND_CR (`crlf_p`=1) or SEND_LF (`crlf_p`=0); otherwise decrement index.
- **SEND_CR:** `data_o`=8'h0D, `valid_o`=1; on transfer, go to SEND_LF.
- **SEND_LF:** `data_o`=8'h0A, `valid_o`=1; on transfer, go to IDLE with `ready_o`=1 on the next cycle.
- **Backpressure:** while `valid_o`=1 and `ready_i`=0, `data_o` holds stable. `valid_o` never drops without a transfer.
- **Busy:** `valid_i` is ignored outside IDLE. The upstream producer must hold its value until accepted.
- **Widths:**
  - 16-bit input gives a maximum of 5 digits (65535).
  - BCD register is 20 bits, digit index is 3 bits, iteration count is 5 bits.
  - No overflow is possible.

## Timing
- All outputs are registered; there is no combinational path from `valid_i`/`ready_i` to any output.
- For a value accepted in cycle T:
  - CONVERT occupies T+1..T+16;
  - LOAD occupies T+17;
  - `valid_o` first asserts at T+18.
- With `ready_i` held at 1, each byte occupies one cycle. A message of N digits plus terminator then ends at T+18+N+(1 if `crlf_p`) cycles, inclusive of the LF cycle.
- `ready_o` reasserts the cycle after the LF transfer, so back-to-back values are accepted with one idle cycle between messages.
- A transfer and a state change in the same cycle are normal. The next byte appears on the following cycle.

## Structure
- Add `ASCII_ZERO` (8'h30), `ASCII_CR` (8'h0D) and `ASCII_LF` (8'h0A) as constants in the shared `tuner_pkg`. The state enum stays local.
- Sub-module `bin2bcd_seq`: 16-bit iterative double-dabble.
  - Interface: `start`, `bin[15:0]`, `done` (one-cycle pulse), `bcd[19:0]`.
  - The top FSM waits on `done` in place of its own iteration counter; the LOAD timing above is preserved.
- The top level holds the FSM, digit index and output registers.

## Test plan
- **Value 440**, `ready_i`=1 → bytes 34,34,30,0D,0A. First `valid_o` at T+18; `ready_o` high again one cycle after 0A.
- **Value 0** → 30,0D,0A. **Value 65535** → 36,35,35,33,35,0D,0A. **Value 10** → 31,30,0D,0A, with no leading zeros.
- **Value 1234** with `ready_i` randomly low 50% of cycles → same byte sequence 31,32,33,34,0D,0A; `data_o` stable while stalled; no duplicated or dropped bytes.
- **`valid_i` pulsed with 999 while 440 is in progress** → ignored; `ready_o`=0 throughout; only "440\r\n" is emitted.
- **Reset asserted during the second digit of 440** → `valid_o`=0 and `ready_o`=0 immediately. After release `ready_o`=1; a new value 7 yields 37,0D,0A.
- **`crlf_p`=0, value 440** → 34,34,30,0A. **Back-to-back 1 then 2** → 31,0D,0A,32,0D,0A.

Source files
------------

// File: rtl/tuner_pkg.sv
// rtl/tuner_pkg.sv - shared ASCII constants and BCD digit helpers
package tuner_pkg;

   localparam logic [7:0] ASCII_ZERO = 8'h30;
   localparam logic [7:0] ASCII_CR   = 8'h0D;
   localparam logic [7:0] ASCII_LF   = 8'h0A;

   // Position of the most significant nonzero BCD digit; 0 when all digits are zero
   function automatic logic [2:0] msd_index(input logic [19:0] bcd);
      logic [2:0] idx;
      idx = 3'd0;
      for (int i = 0; i < 5; i++) begin
         if (bcd[i*4 +: 4] != 4'd0) idx = 3'(i);
      end
      return idx;
   endfunction

   // ASCII character of BCD digit number idx (0 = units)
   function automatic logic [7:0] digit_char(input logic [19:0] bcd, input logic [2:0] idx);
      logic [3:0] d;
      case (idx)
         3'd0:    d = bcd[3:0];
         3'd1:    d = bcd[7:4];
         3'd2:    d = bcd[11:8];
         3'd3:    d = bcd[15:12];
         3'd4:    d = bcd[19:16];
         default: d = 4'd0;
      endcase
      return ASCII_ZERO + {4'h0, d};
   endfunction

endpackage

// File: rtl/uart_dec_formatter_if.sv
// rtl/uart_dec_formatter_if.sv - value input and byte output handshakes of the formatter
interface uart_dec_formatter_if;

   logic [15:0] value_i;
   logic        valid_i;
   logic        ready_o;
   logic [7:0]  data_o;
   logic        valid_o;
   logic        ready_i;

   // Producer of values and consumer of bytes (the environment)
   modport master (
      output value_i, valid_i, ready_i,
      input  ready_o, data_o, valid_o
   );

   // The formatter itself
   modport slave (
      input  value_i, valid_i, ready_i,
      output ready_o, data_o, valid_o
   );

endinterface

// File: rtl/bin2bcd_seq.sv
// rtl/bin2bcd_seq.sv - 16-bit iterative double-dabble, one bit per cycle
module bin2bcd_seq
   import tuner_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [15:0] bin,
   output logic        done,
   output logic [19:0] bcd
);

   logic [15:0] shift;
   logic [19:0] bcd_r;
   logic [19:0] adj;
   logic [4:0]  count;
   logic        busy;

   // Add-3 correction of every nibble that would overflow past 9 on the next shift
   always_comb begin
      adj = bcd_r;
      for (int i = 0; i < 5; i++) begin
         if (bcd_r[i*4 +: 4] >= 4'd5) adj[i*4 +: 4] = bcd_r[i*4 +: 4] + 4'd3;
      end
   end

   // Load on start, then correct-and-shift once per cycle for 16 cycles; result holds afterwards
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         shift <= 16'h0000;
         bcd_r <= 20'h00000;
         count <= 5'd0;
         busy  <= 1'b0;
      end else if (start) begin
         shift <= bin;
         bcd_r <= 20'h00000;
         count <= 5'd16;
         busy  <= 1'b1;
      end else if (busy) begin
         {bcd_r, shift} <= {adj[18:0], shift, 1'b0};
         count          <= count - 5'd1;
         if (count == 5'd1) busy <= 1'b0;
      end
   end

   // done marks the final iteration so the caller sees the finished BCD on the next cycle
   assign done = busy && (count == 5'd1);
   assign bcd  = bcd_r;

endmodule

// File: rtl/uart_dec_formatter.sv
// rtl/uart_dec_formatter.sv - formats a 16-bit value as decimal ASCII plus line ending
module uart_dec_formatter
   import tuner_pkg::*;
#(
   parameter bit crlf_p = 1'b1
) (
   input logic                 clk_i,
   input logic                 reset_i,
   uart_dec_formatter_if.slave bus
);

   typedef enum logic [2:0] {
      IDLE,
      CONVERT,
      LOAD,
      SEND_DIGIT,
      SEND_CR,
      SEND_LF
   } state_t;

   state_t      state;
   logic [2:0]  idx;
   logic        ready_r;
   logic        valid_r;
   logic [7:0]  data_r;
   logic        accept;
   logic        xfer;
   logic        conv_done;
   logic [19:0] bcd;

   assign accept = (state == IDLE) && ready_r && bus.valid_i;
   assign xfer   = valid_r && bus.ready_i;

   bin2bcd_seq u_conv (
      .clk   (clk_i),
      .rst   (reset_i),
      .start (accept),
      .bin   (bus.value_i),
      .done  (conv_done),
      .bcd   (bcd)
   );

   // Message sequencer; every output is a register updated together with the state
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state   <= IDLE;
         idx     <= 3'd0;
         ready_r <= 1'b0;
         valid_r <= 1'b0;
         data_r  <= 8'h00;
      end else begin
         case (state)
            IDLE: begin
               valid_r <= 1'b0;
               if (accept) begin
                  ready_r <= 1'b0;
                  state   <= CONVERT;
               end else begin
                  ready_r <= 1'b1;
               end
            end
            CONVERT: begin
               if (conv_done) state <= LOAD;
            end
            LOAD: begin
               idx     <= msd_index(bcd);
               data_r  <= digit_char(bcd, msd_index(bcd));
               valid_r <= 1'b1;
               state   <= SEND_DIGIT;
            end
            SEND_DIGIT: begin
               if (xfer) begin
                  if (idx == 3'd0) begin
                     if (crlf_p) begin
                        data_r <= ASCII_CR;
                        state  <= SEND_CR;
                     end else begin
                        data_r <= ASCII_LF;
                        state  <= SEND_LF;
                     end
                  end else begin
                     idx    <= idx - 3'd1;
                     data_r <= digit_char(bcd, idx - 3'd1);
                  end
               end
            end
            SEND_CR: begin
               if (xfer) begin
                  data_r <= ASCII_LF;
                  state  <= SEND_LF;
               end
            end
            SEND_LF: begin
               if (xfer) begin
                  valid_r <= 1'b0;
                  data_r  <= 8'h00;
                  ready_r <= 1'b1;
                  state   <= IDLE;
               end
            end
            default: begin
               valid_r <= 1'b0;
               ready_r <= 1'b0;
               state   <= IDLE;
            end
         endcase
      end
   end

   assign bus.ready_o = ready_r;
   assign bus.valid_o = valid_r;
   assign bus.data_o  = data_r;

endmodule
